gen_mq_sfifo: RTL and testbench
===============================

GEN_MQ_SFIFO -- requirements
Module: gen_mq_sfifo

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH_CH, default 2: channel-select width; NUM_CH = 2**WIDTH_CH.
- WIDTH_DATA, default 32: word width.
- WIDTH_ADDR, default 9: per-channel depth exponent; DEPTH = 2**WIDTH_ADDR.
- WATERAGE_UP, default 1: alfull when count >= DEPTH-WATERAGE_UP.
- WATERAGE_DOWN, default 1: alempty when count <= WATERAGE_DOWN.
- OVERLIMIT_CHECK, default 1: 1 enables the error flags; 0 holds them at 0.

REQ-002 The block SHALL have these ports, in this order:
- sys_clk  in  1  single clock, all logic rising-edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- wdata  in  WIDTH_DATA  write word.
- wen  in  1  write request.
- wch  in  WIDTH_CH  write channel.
- ren  in  1  read request.
- rch  in  WIDTH_CH  read channel.
- rdata  out  WIDTH_DATA  registered read word.
- rvalid  out  1  rdata valid.
- rdata_ch  out  WIDTH_CH  channel of rdata.
- flush  in  NUM_CH  per-channel synchronous clear.
- err_clr  in  1  clears the sticky errors.
- full, alfull, empty, alempty  out  NUM_CH each  per-channel flags, bit c = channel c.
- deep  out  NUM_CH*(WIDTH_ADDR+1)  per-channel counts, channel c at bits [c*(WIDTH_ADDR+1) +: WIDTH_ADDR+1].
- ovf_err, udf_err  out  1 each  sticky overflow / underflow.

Function
REQ-003 Storage SHALL be one memory of NUM_CH*DEPTH words; channel c SHALL own addresses c*DEPTH .. c*DEPTH+DEPTH-1, each operated as an independent circular buffer with a WIDTH_ADDR-bit write pointer, a WIDTH_ADDR-bit read pointer and a (WIDTH_ADDR+1)-bit count.
REQ-004 A write SHALL be accepted when wen=1, full[wch]=0 and flush[wch]=0. On acceptance, wdata is stored at the write pointer of wch, and that pointer increments modulo DEPTH.
REQ-005 A read SHALL be accepted when ren=1, empty[rch]=0 and flush[rch]=0. On acceptance, the word at the read pointer of rch is registered into rdata and that pointer increments modulo DEPTH.
REQ-006 Read latency SHALL be 1 cycle: the cycle after an accepted read, rvalid=1 and rdata_ch = the rch of that read. In all other cycles rvalid=0, and rdata and rdata_ch hold their last values.
REQ-007 Per channel c, count_next SHALL equal count + write accepted on c - read accepted on c. A same-channel write and read in one cycle SHALL leave the count unchanged.
REQ-008 Same-channel write and read in one cycle SHALL be checked against the pre-cycle count: at count=0 only the write is accepted (no bypass); at count=DEPTH only the read is accepted.
REQ-009 Flags SHALL be combinational from the registered counts: full = (count==DEPTH); empty = (count==0); alfull = (count >= DEPTH-WATERAGE_UP); alempty = (count <= WATERAGE_DOWN). deep SHALL carry the counts directly.
REQ-010 flush[c]=1 SHALL zero both pointers and the count of channel c at the next edge.
- A write or read to c in the same cycle is discarded and raises no error.
- A read accepted in the cycle before the flush still returns valid data.
REQ-011 With OVERLIMIT_CHECK=1:
- A write rejected only because of full SHALL set ovf_err.
- A read rejected only because of empty SHALL set udf_err.
- Both flags stay set until an err_clr cycle; a set in the same cycle as err_clr wins.
- With OVERLIMIT_CHECK=0, both flags are constant 0 and illegal accesses are still blocked.
REQ-012 A read and a write SHALL never target the same address in one cycle; no read-during-write behaviour is required of the memory.

Reset
REQ-013 sys_rst_n=0 SHALL immediately, independent of sys_clk, force:
- all pointers and counts, rvalid, rdata, rdata_ch, ovf_err and udf_err to 0;
- hence empty and alempty all 1, full and alfull all 0, deep all 0.
REQ-014 Memory contents SHALL NOT be reset.
REQ-015 Reset SHALL override any operation in progress; a read accepted in the cycle reset asserts produces no rvalid.

Verification (WIDTH_CH=2, WIDTH_ADDR=3, DEPTH=8, WATERAGE_UP/DOWN=1)
REQ-016 Write 0x10..0x17 to ch1 -> alfull[1]=1 after the 7th write, full[1]=1 and deep ch1=8 after the 8th; a 9th write of 0x18 is dropped and ovf_err=1; ch0, ch2 and ch3 stay empty.
REQ-017 Write 0xA to ch0, then 0xB to ch2; read ch2 -> next cycle rvalid=1, rdata=0xB, rdata_ch=2; deep ch0=1, empty[2]=1.
REQ-018 Fill ch3 to 4 entries, then apply 12 cycles of simultaneous wen/ren on ch3 -> count stays 4 throughout, pointers wrap, and read data exits in exact write order.
REQ-019 Read empty ch0 -> rvalid=0 and udf_err=1; one err_clr cycle -> udf_err=0; err_clr in the same cycle as a new underflow -> udf_err=1.
REQ-020 Ch1 holds 5 entries; flush[1]=1 together with wen on ch1 -> next cycle deep ch1=0, empty[1]=1, ovf_err=0; the next write and read of ch1 returns the new word.
REQ-021 Assert sys_rst_n=0 mid-burst between clock edges -> all outputs reach their REQ-013 values without waiting for a clock edge; after release, ch0 accepts a write in the first cycle.

Source files
------------

// File: rtl/gen_mq_sfifo.sv
// Multi-queue synchronous FIFO: NUM_CH independent circular buffers sharing one
// memory, with one-cycle registered reads, per-channel flags/counts and sticky errors.
module gen_mq_sfifo #(
  parameter int WIDTH_CH        = 2,
  parameter int WIDTH_DATA      = 32,
  parameter int WIDTH_ADDR      = 9,
  parameter int WATERAGE_UP     = 1,
  parameter int WATERAGE_DOWN   = 1,
  parameter int OVERLIMIT_CHECK = 1
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst_n,
  input  logic [WIDTH_DATA-1:0]                   wdata,
  input  logic                                    wen,
  input  logic [WIDTH_CH-1:0]                     wch,
  input  logic                                    ren,
  input  logic [WIDTH_CH-1:0]                     rch,
  output logic [WIDTH_DATA-1:0]                   rdata,
  output logic                                    rvalid,
  output logic [WIDTH_CH-1:0]                     rdata_ch,
  input  logic [(2**WIDTH_CH)-1:0]                flush,
  input  logic                                    err_clr,
  output logic [(2**WIDTH_CH)-1:0]                full,
  output logic [(2**WIDTH_CH)-1:0]                alfull,
  output logic [(2**WIDTH_CH)-1:0]                empty,
  output logic [(2**WIDTH_CH)-1:0]                alempty,
  output logic [(2**WIDTH_CH)*(WIDTH_ADDR+1)-1:0] deep,
  output logic                                    ovf_err,
  output logic                                    udf_err
);

  localparam int NUM_CH = 2**WIDTH_CH;
  localparam int DEPTH  = 2**WIDTH_ADDR;
  localparam int CW     = WIDTH_ADDR + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - WATERAGE_UP);
  localparam logic [CW-1:0] AE_LVL   = CW'(WATERAGE_DOWN);

  logic [WIDTH_DATA-1:0] mem [NUM_CH*DEPTH];
  logic [WIDTH_ADDR-1:0] wptr [NUM_CH];
  logic [WIDTH_ADDR-1:0] rptr [NUM_CH];

  logic                           wr_ok;
  logic                           rd_ok;
  logic                           wr_full_rej;
  logic                           rd_empty_rej;
  logic [WIDTH_CH+WIDTH_ADDR-1:0] waddr;
  logic [WIDTH_CH+WIDTH_ADDR-1:0] raddr;

  // Flags come from pre-cycle counts, so a same-channel write+read at empty/full
  // naturally accepts only the legal half (no bypass).
  assign wr_ok        = wen && !full[wch] && !flush[wch];
  assign rd_ok        = ren && !empty[rch] && !flush[rch];
  assign wr_full_rej  = wen && full[wch] && !flush[wch];
  assign rd_empty_rej = ren && empty[rch] && !flush[rch];

  // Channel c occupies addresses c*DEPTH .. c*DEPTH+DEPTH-1.
  assign waddr = {wch, wptr[wch]};
  assign raddr = {rch, rptr[rch]};

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rvalid   <= 1'b0;
      rdata    <= '0;
      rdata_ch <= '0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata    <= mem[raddr];
        rdata_ch <= rch;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH_ADDR-1:0] wptr_reg;
      logic [WIDTH_ADDR-1:0] rptr_reg;
      logic [CW-1:0]         cnt_reg;
      logic                  wr_hit;
      logic                  rd_hit;

      assign wr_hit = wr_ok && (wch == WIDTH_CH'(gi));
      assign rd_hit = rd_ok && (rch == WIDTH_CH'(gi));

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          wptr_reg <= '0;
          rptr_reg <= '0;
          cnt_reg  <= '0;
        end else if (flush[gi]) begin
          wptr_reg <= '0;
          rptr_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (wr_hit) wptr_reg <= wptr_reg + WIDTH_ADDR'(1);
          if (rd_hit) rptr_reg <= rptr_reg + WIDTH_ADDR'(1);
          cnt_reg <= cnt_reg + CW'(wr_hit) - CW'(rd_hit);
        end
      end

      assign wptr[gi]             = wptr_reg;
      assign rptr[gi]             = rptr_reg;
      assign full[gi]             = (cnt_reg == CNT_FULL);
      assign empty[gi]            = (cnt_reg == '0);
      assign alfull[gi]           = (cnt_reg >= AF_LVL);
      assign alempty[gi]          = (cnt_reg <= AE_LVL);
      assign deep[gi*CW +: CW]    = cnt_reg;
    end

    if (OVERLIMIT_CHECK != 0) begin : g_err
      // A new error in the err_clr cycle takes priority over the clear.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          ovf_err <= 1'b0;
          udf_err <= 1'b0;
        end else begin
          if (wr_full_rej)  ovf_err <= 1'b1;
          else if (err_clr) ovf_err <= 1'b0;
          if (rd_empty_rej) udf_err <= 1'b1;
          else if (err_clr) udf_err <= 1'b0;
        end
      end
    end else begin : g_no_err
      assign ovf_err = 1'b0;
      assign udf_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_gen_mq_sfifo.sv
// Directed scoreboard bench for gen_mq_sfifo (4 channels, depth 8): expected reads
// are queued at issue time and a negedge monitor compares them against rvalid output.
module tb_gen_mq_sfifo;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] wdata;
  logic        wen;
  logic [1:0]  wch;
  logic        ren;
  logic [1:0]  rch;
  logic [31:0] rdata;
  logic        rvalid;
  logic [1:0]  rdata_ch;
  logic [3:0]  flush;
  logic        err_clr;
  logic [3:0]  full, alfull, empty, alempty;
  logic [15:0] deep;
  logic        ovf_err, udf_err;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  gen_mq_sfifo #(
    .WIDTH_CH(2), .WIDTH_DATA(32), .WIDTH_ADDR(3),
    .WATERAGE_UP(1), .WATERAGE_DOWN(1), .OVERLIMIT_CHECK(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wdata(wdata), .wen(wen), .wch(wch),
    .ren(ren), .rch(rch), .rdata(rdata), .rvalid(rvalid), .rdata_ch(rdata_ch),
    .flush(flush), .err_clr(err_clr), .full(full), .alfull(alfull), .empty(empty),
    .alempty(alempty), .deep(deep), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dp(input int c);
    return deep[c*4 +: 4];
  endfunction

  // Monitor: every rvalid must match the oldest outstanding expected read.
  always @(negedge sys_clk) begin
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got ch=%0d data=%h expected no read", rdata_ch, rdata);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        $display("read ch=%0d data=%h", rdata_ch, rdata);
        check("rdata", 64'(rdata), 64'(e[31:0]));
        check("rdata_ch", 64'(rdata_ch), 64'(e[33:32]));
      end
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d);
    wen = 1'b1; wch = ch; wdata = d;
    cyc();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ch, input bit acc, input logic [31:0] d);
    ren = 1'b1; rch = ch;
    if (acc) exp_q.push_back({ch, d});
    cyc();
    ren = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; wdata = '0; wen = 1'b0; wch = '0; ren = 1'b0; rch = '0;
    flush = '0; err_clr = 1'b0;
    cyc(); cyc();
    check("rst_empty", 64'(empty), 64'hF);
    check("rst_alempty", 64'(alempty), 64'hF);
    check("rst_full", 64'(full), 64'h0);
    check("rst_alfull", 64'(alfull), 64'h0);
    check("rst_deep", 64'(deep), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_errs", 64'({ovf_err, udf_err}), 64'h0);
    sys_rst_n = 1'b1;

    // Fill ch1 to full, then overflow.
    for (int i = 0; i < 8; i++) begin
      wr(2'd1, 32'h10 + 32'(i));
      if (i == 5) check("alfull_6", 64'(alfull[1]), 64'h0);
      if (i == 6) check("alfull_7", 64'(alfull[1]), 64'h1);
      if (i == 6) check("full_7", 64'(full[1]), 64'h0);
    end
    check("full_8", 64'(full[1]), 64'h1);
    check("deep1_8", 64'(dp(1)), 64'h8);
    check("ovf_before", 64'(ovf_err), 64'h0);
    wr(2'd1, 32'h18);
    check("ovf_set", 64'(ovf_err), 64'h1);
    check("deep1_9", 64'(dp(1)), 64'h8);
    check("empty_others", 64'(empty), 64'hD);
    check("alempty_others", 64'(alempty), 64'hD);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("ovf_clr", 64'(ovf_err), 64'h0);
    for (int i = 0; i < 8; i++) begin
      rd(2'd1, 1'b1, 32'h10 + 32'(i));
      if (i == 5) check("alempty_2", 64'(alempty[1]), 64'h0);
      if (i == 6) check("alempty_1", 64'(alempty[1]), 64'h1);
    end
    check("empty1_drained", 64'(empty[1]), 64'h1);

    // Cross-channel independence.
    wr(2'd0, 32'hA);
    wr(2'd2, 32'hB);
    rd(2'd2, 1'b1, 32'hB);
    check("deep0_1", 64'(dp(0)), 64'h1);
    check("empty2", 64'(empty[2]), 64'h1);
    rd(2'd0, 1'b1, 32'hA);

    // Steady-state simultaneous traffic on ch3 with pointer wrap.
    for (int i = 0; i < 4; i++) wr(2'd3, 32'h30 + 32'(i));
    for (int i = 0; i < 12; i++) begin
      wen = 1'b1; wch = 2'd3; wdata = 32'h34 + 32'(i);
      ren = 1'b1; rch = 2'd3;
      exp_q.push_back({2'd3, 32'h30 + 32'(i)});
      cyc();
      check("deep3_steady", 64'(dp(3)), 64'h4);
    end
    wen = 1'b0; ren = 1'b0;
    for (int i = 0; i < 4; i++) rd(2'd3, 1'b1, 32'h3C + 32'(i));

    // Underflow and sticky-error clearing.
    rd(2'd0, 1'b0, 32'h0);
    check("udf_set", 64'(udf_err), 64'h1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("udf_clr", 64'(udf_err), 64'h0);
    err_clr = 1'b1;
    rd(2'd0, 1'b0, 32'h0);
    err_clr = 1'b0;
    check("udf_set_wins", 64'(udf_err), 64'h1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    // Same-channel write+read at count 0: only the write lands.
    wen = 1'b1; wch = 2'd0; wdata = 32'hC0; ren = 1'b1; rch = 2'd0;
    cyc();
    wen = 1'b0; ren = 1'b0;
    check("nobypass_deep0", 64'(dp(0)), 64'h1);
    check("nobypass_udf", 64'(udf_err), 64'h1);
    err_clr = 1'b1;
    rd(2'd0, 1'b1, 32'hC0);
    err_clr = 1'b0;

    // Flush: read issued the cycle before still returns, flushed write is lost.
    for (int i = 0; i < 5; i++) wr(2'd1, 32'h50 + 32'(i));
    rd(2'd1, 1'b1, 32'h50);
    flush = 4'b0010;
    wr(2'd1, 32'hEE);
    flush = 4'b0000;
    check("flush_deep1", 64'(dp(1)), 64'h0);
    check("flush_empty1", 64'(empty[1]), 64'h1);
    check("flush_ovf", 64'(ovf_err), 64'h0);
    wr(2'd1, 32'h77);
    rd(2'd1, 1'b1, 32'h77);

    // Asynchronous reset between edges right after an accepted read.
    wr(2'd0, 32'h61);
    wr(2'd0, 32'h62);
    ren = 1'b1; rch = 2'd0;
    cyc();
    ren = 1'b0;
    check("pre_rst_rvalid", 64'(rvalid), 64'h1);
    check("pre_rst_rdata", 64'(rdata), 64'h61);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_rvalid", 64'(rvalid), 64'h0);
    check("arst_rdata", 64'(rdata), 64'h0);
    check("arst_deep", 64'(deep), 64'h0);
    check("arst_empty", 64'(empty), 64'hF);
    check("arst_full", 64'(full), 64'h0);
    cyc(); cyc();
    sys_rst_n = 1'b1;
    wr(2'd0, 32'h71);
    check("post_rst_deep0", 64'(dp(0)), 64'h1);
    rd(2'd0, 1'b1, 32'h71);

    cyc(); cyc();
    check("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
